// File: rtl/core85_pkg.sv
// Shared 8085-style definitions: sequencer states, opcode classes and field codes.
// Also reused by the alureg benches.
package core85_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCode,
        StIll,
        StWaitd,
        StData,
        StRreg,
        StWreg,
        StDone
    } seq_state_e;

    localparam logic [1:0] OPC_MISC = 2'b00;
    localparam logic [1:0] OPC_MOV  = 2'b01;
    localparam logic [1:0] OPC_ALU  = 2'b10;
    localparam logic [1:0] OPC_IMM  = 2'b11;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBB = 3'd3;
    localparam logic [2:0] ALU_ANA = 3'd4;
    localparam logic [2:0] ALU_XRA = 3'd5;
    localparam logic [2:0] ALU_ORA = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

endpackage

// File: rtl/alureg_seq_dec.sv
// Combinational opcode classifier for alureg_seq.
// ALUREG_SEQ_IMM_ALU_EN enables 11_ooo_110 as a two-byte ALU-immediate.
module alureg_seq_dec
    import core85_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 3
) (
    input  logic [DATASIZE-1:0] opcode,
    output logic                is_mvi,
    output logic                is_mov,
    output logic                is_alu,
    output logic                is_imm,
    output logic                is_ill
);

    localparam logic [ADDRSIZE-1:0] MEM_SEL = ADDRSIZE'(REG_M);

    logic [1:0]          cls;
    logic [ADDRSIZE-1:0] dst;
    logic [ADDRSIZE-1:0] src;

    assign cls = opcode[DATASIZE-1 -: 2];
    assign dst = opcode[2*ADDRSIZE-1 -: ADDRSIZE];
    assign src = opcode[ADDRSIZE-1:0];

    always_comb begin
        // 01_110_110 matches neither MVI nor MOV and so falls through to illegal
        is_mvi = (cls == OPC_MOV) && (src == MEM_SEL) && (dst != MEM_SEL);
        is_mov = (cls == OPC_MOV) && (src != MEM_SEL);
        is_alu = (cls == OPC_ALU);
`ifdef ALUREG_SEQ_IMM_ALU_EN
        is_imm = (cls == OPC_IMM) && (src == MEM_SEL);
`else
        is_imm = 1'b0;
`endif
        is_ill = !(is_mvi || is_mov || is_alu || is_imm);
    end

endmodule

// File: rtl/alureg_seq.sv
// Byte-stream sequencer issuing alureg strobes for MOV, MVI and register-ALU ops.
// Optional macro ALUREG_SEQ_IMM_ALU_EN adds two-byte ALU-immediate ops (see alureg_seq_dec).
module alureg_seq
    import core85_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATASIZE-1:0] bus_data,
    output logic                enb_code,
    output logic                enb_data,
    output logic                enb_rreg,
    output logic                enb_wreg,
    output logic                busy,
    output logic                done,
    output logic                ill_op
);

    seq_state_e          state_q, state_d;
    logic [DATASIZE-1:0] bus_d;
    logic                xfer;
    logic                is_mvi, is_mov, is_alu, is_imm, is_ill;

    // bus_data holds the opcode while in CODE, so decode straight from it
    alureg_seq_dec #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_dec (
        .opcode (bus_data),
        .is_mvi (is_mvi),
        .is_mov (is_mov),
        .is_alu (is_alu),
        .is_imm (is_imm),
        .is_ill (is_ill)
    );

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_data;
        in_ready = (state_q == StIdle) || (state_q == StWaitd);
        xfer     = in_valid && in_ready;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StCode;
                    bus_d   = in_data;
                end
            end
            StCode: begin
                if (is_ill) begin
                    state_d = StIll;
                end else if (is_mvi || is_imm) begin
                    state_d = StWaitd;
                end else if (is_mov || is_alu) begin
                    state_d = StRreg;
                end else begin
                    state_d = StIll;
                end
            end
            StIll:   state_d = StIdle;
            StWaitd: begin
                if (xfer) begin
                    state_d = StData;
                    bus_d   = in_data;
                end
            end
            StData:  state_d = StRreg;
            StRreg:  state_d = StWreg;
            StWreg:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            bus_data <= '0;
            enb_code <= 1'b0;
            enb_data <= 1'b0;
            enb_rreg <= 1'b0;
            enb_wreg <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ill_op   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_data <= bus_d;
            enb_code <= (state_d == StCode);
            enb_data <= (state_d == StData);
            enb_rreg <= (state_d == StRreg) || (state_d == StWreg);
            enb_wreg <= (state_d == StWreg);
            busy     <= (state_d != StIdle);
            done     <= (state_d == StDone);
            ill_op   <= (state_d == StIll);
        end
    end

endmodule

// File: tb/tb_alureg_seq.sv
// Self-checking bench for alureg_seq: directed scenarios plus random opcode streams
// compared cycle by cycle against a transaction-level expected trace.
module tb_alureg_seq;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_data;
    logic       enb_code, enb_data, enb_rreg, enb_wreg, busy, done, ill_op;

    int n_checks = 0;
    int n_errors = 0;

    alureg_seq #(
        .DATASIZE (8),
        .ADDRSIZE (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bus_data (bus_data),
        .enb_code (enb_code),
        .enb_data (enb_data),
        .enb_rreg (enb_rreg),
        .enb_wreg (enb_wreg),
        .busy     (busy),
        .done     (done),
        .ill_op   (ill_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dut_vec;
    assign dut_vec = {bus_data, enb_code, enb_data, enb_rreg, enb_wreg, busy, done, ill_op,
                      in_ready};

    function automatic logic [15:0] vec(input logic [7:0] b, input logic code, input logic dat,
                                        input logic rreg, input logic wreg, input logic bsy,
                                        input logic dn, input logic ill, input logic rdy);
        return {b, code, dat, rreg, wreg, bsy, dn, ill, rdy};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 = illegal, 1 = single-byte register op, 2 = two-byte (opcode + operand)
    function automatic int op_kind(input int op);
        int hi, mid, lo;
        hi  = op / 64;
        mid = (op / 8) % 8;
        lo  = op % 8;
        if (hi == 1) begin
            if (lo == 6) return (mid == 6) ? 0 : 2;
            return 1;
        end
        if (hi == 2) return 1;
`ifdef ALUREG_SEQ_IMM_ALU_EN
        if (hi == 3 && lo == 6) return 2;
`endif
        return 0;
    endfunction

    // Precondition: DUT idle, at a sample point. Leaves DUT idle at a sample point.
    // hold keeps in_valid high with next_op on every cycle the DUT must ignore.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] operand,
                          input int wait_cyc, input logic hold, input logic [7:0] next_op);
        logic [15:0] exp_q[$];
        logic        drv_v[$];
        logic [7:0]  drv_d[$];
        logic [7:0]  rb;
        int          kind;
        kind = op_kind(int'(op));
        exp_q.push_back(vec(op, 1, 0, 0, 0, 1, 0, 0, 0));
        if (kind == 0) begin
            exp_q.push_back(vec(op, 0, 0, 0, 0, 1, 0, 1, 0));
            exp_q.push_back(vec(op, 0, 0, 0, 0, 0, 0, 0, 1));
        end else if (kind == 1) begin
            exp_q.push_back(vec(op, 0, 0, 1, 0, 1, 0, 0, 0));
            exp_q.push_back(vec(op, 0, 0, 1, 1, 1, 0, 0, 0));
            exp_q.push_back(vec(op, 0, 0, 0, 0, 1, 1, 0, 0));
            exp_q.push_back(vec(op, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            for (int j = 0; j <= wait_cyc; j++) exp_q.push_back(vec(op, 0, 0, 0, 0, 1, 0, 0, 1));
            exp_q.push_back(vec(operand, 0, 1, 0, 0, 1, 0, 0, 0));
            exp_q.push_back(vec(operand, 0, 0, 1, 0, 1, 0, 0, 0));
            exp_q.push_back(vec(operand, 0, 0, 1, 1, 1, 0, 0, 0));
            exp_q.push_back(vec(operand, 0, 0, 0, 0, 1, 1, 0, 0));
            exp_q.push_back(vec(operand, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            rb = 8'($urandom);
            if (kind == 2 && i >= 1 && i <= wait_cyc + 1) begin
                drv_v.push_back(i == wait_cyc + 1);
                drv_d.push_back((i == wait_cyc + 1) ? operand : rb);
            end else begin
                drv_v.push_back(hold);
                drv_d.push_back(hold ? next_op : rb);
            end
        end
        in_data  = op;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s op=%02h cyc%0d", tag, op, i), 32'(dut_vec), 32'(exp_q[i]));
            if (i < exp_q.size() - 1) begin
                in_valid = drv_v[i];
                in_data  = drv_d[i];
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    logic [7:0] ops[48];

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        check_eq("reset_held", 32'(dut_vec), 32'(vec(8'h00, 0, 0, 0, 0, 0, 0, 0, 1)));
        rst = 1'b0;
        in_data = 8'h5A;
        step();
        check_eq("idle_no_valid", 32'(dut_vec), 32'(vec(8'h00, 0, 0, 0, 0, 0, 0, 0, 1)));

        run_op("mvi_a", 8'h7E, 8'hAA, 0, 1'b0, 8'h00);
        run_op("mov_b_a", 8'h47, 8'h00, 0, 1'b0, 8'h00);
        run_op("xra_a_b2b", 8'hAF, 8'h00, 0, 1'b1, 8'h4F);
        run_op("mov_c_a", 8'h4F, 8'h00, 0, 1'b0, 8'h00);
        run_op("ill_00", 8'h00, 8'h00, 0, 1'b0, 8'h00);
        run_op("ill_76", 8'h76, 8'h00, 0, 1'b0, 8'h00);
        run_op("mvi_wait5", 8'h0E | 8'h40, 8'h3C, 5, 1'b0, 8'h00);

        // Reset in the middle of a MOV, while in RREG
        in_data  = 8'h47;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("pre_rst_rreg", 32'(dut_vec), 32'(vec(8'h47, 0, 0, 1, 0, 1, 0, 0, 0)));
        rst = 1'b1;
        step();
        check_eq("rst_mid_op", 32'(dut_vec), 32'(vec(8'h00, 0, 0, 0, 0, 0, 0, 0, 1)));
        rst = 1'b0;
        step();
        check_eq("post_rst_idle", 32'(dut_vec), 32'(vec(8'h00, 0, 0, 0, 0, 0, 0, 0, 1)));

        run_op("imm_ee", 8'hEE, 8'h55, 0, 1'b1, 8'h55);
        run_op("after_ee", 8'h55, 8'h00, 0, 1'b0, 8'h00);

        for (int i = 0; i < 48; i++) ops[i] = 8'($urandom);
        for (int i = 0; i < 48; i++) begin
            run_op("rand", ops[i], 8'($urandom), int'($urandom_range(0, 3)),
                   (i < 47) ? 1'($urandom_range(0, 1)) : 1'b0, (i < 47) ? ops[i + 1] : 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
